frame_loader: RTL and testbench
===============================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame header byte.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000, maximum idle cycles between bytes inside a frame.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port rx_valid  in  1  one-cycle strobe, rx_byte valid.
REQ-006 SHALL have port rx_byte  in  8  received UART byte.
REQ-007 SHALL have port frame_done  in  1  one-cycle strobe from the panel scanner at end of scan (row wrap).
REQ-008 SHALL have port rd_col  in  4  front-bank column address from the scanner.
REQ-009 SHALL have port rd_data  out  8  front-bank column data, combinational from rd_col.
REQ-010 SHALL have port swap_pending  out  1  a validated back bank awaits display.
REQ-011 SHALL have port busy  out  1  high in DATA or CHECK.
REQ-012 SHALL have port frame_ok  out  1  one-cycle pulse, checksum matched.
REQ-013 SHALL have port frame_err  out  1  one-cycle pulse, checksum mismatch or timeout.
REQ-014 SHALL have port dropped  out  1  one-cycle pulse, header ignored because swap_pending.

Function
REQ-015 SHALL hold two 16x8 banks (front, back); a bank_sel bit selects front; rd_data = front[rd_col].
REQ-016 SHALL implement states IDLE, DATA, CHECK.
REQ-017 IDLE: rx_valid with rx_byte==SYNC_BYTE and swap_pending=0 -> DATA, byte index=0, running XOR=0.
REQ-018 IDLE: rx_valid with rx_byte==SYNC_BYTE and swap_pending=1 -> stay IDLE, pulse dropped; non-sync bytes ignored silently.
REQ-019 DATA: each rx_valid writes rx_byte to back[index], XORs it into the checksum, increments index; at the 16th byte (index 15) -> CHECK.
REQ-020 DATA: bytes equal to SYNC_BYTE are data, not headers.
REQ-021 CHECK: rx_valid with rx_byte==running XOR -> pulse frame_ok, set swap_pending, -> IDLE; otherwise pulse frame_err, -> IDLE, back bank contents undefined for display but never shown.
REQ-022 A 16-bit gap counter SHALL clear on every rx_valid and on entry to DATA; reaching TIMEOUT_CYCLES in DATA or CHECK -> pulse frame_err, -> IDLE.
REQ-023 frame_done with swap_pending=1 (registered value) SHALL toggle bank_sel and clear swap_pending in the same edge; rd_data reflects the new bank from the next cycle.
REQ-024 frame_done with swap_pending=0 SHALL have no effect.
REQ-025 frame_ok and frame_done in the same cycle: swap_pending becomes 1, swap occurs at the next frame_done.
REQ-026 Writes SHALL only target the back bank; front bank is never modified outside reset.
REQ-027 frame_ok, frame_err, dropped SHALL be mutually exclusive and registered.

Reset
REQ-028 On reset low at a clock edge: state=IDLE, both banks all zero, bank_sel=0, swap_pending=0, busy=0, frame_ok=frame_err=dropped=0, index=0, checksum=0, gap counter=0; rd_data=0.
REQ-029 Reset mid-frame SHALL abandon the frame without any pulse.

Structure
REQ-030 Shared package SHALL hold state encoding, FRAME_COLS=16, default SYNC_BYTE, column width 4.
REQ-031 One sub-module frame_bank (16x8 register array, one sync write port, one async read port, sync clear) SHALL be instantiated twice.

Verification
REQ-032 Send A5, bytes 01..10, checksum 10 (XOR of 01..10), then frame_done -> frame_ok pulse, swap_pending 1->0, rd_col=3 gives 8'h04.
REQ-033 Same frame with checksum 00 -> frame_err pulse, swap_pending stays 0, rd_data unchanged (all zero after reset).
REQ-034 Valid frame, no frame_done, second A5 -> dropped pulse, state stays IDLE, after frame_done first frame displayed.
REQ-035 A5 then 5 bytes then silence for TIMEOUT_CYCLES -> frame_err exactly TIMEOUT_CYCLES after last byte, busy falls.
REQ-036 Checksum byte and frame_done in same cycle -> no swap that cycle; swap at next frame_done.
REQ-037 Reset low after 8 data bytes -> no pulses, busy=0, all rd_data=0, next valid frame accepted normally.

Source files
------------

// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader: FSM encoding, frame geometry
// and the default header byte.
package frame_loader_pkg;

  // Number of columns (data bytes) in one frame and the column address width.
  localparam int FRAME_COLS = 16;
  localparam int COL_W      = 4;

  // Width of the inter-byte gap counter.
  localparam int GAP_W = 16;

  // Header byte that opens a frame unless overridden at instantiation.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Receiver states: waiting for a header, collecting data, awaiting checksum.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  // True when the column index points at the final data byte of a frame.
  function automatic logic is_last_col(input logic [COL_W-1:0] idx);
    return idx == COL_W'(FRAME_COLS - 1);
  endfunction

endpackage

// File: rtl/frame_loader_bank.sv
// One 16x8 display bank: a register per column, synchronous write port,
// asynchronous read port and synchronous clear on active-low reset.
module frame_bank
  import frame_loader_pkg::*;
(
  input  logic             clk,
  input  logic             reset_i,   // active low, synchronous
  input  logic             we_i,
  input  logic [COL_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [COL_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [FRAME_COLS];

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_COLS; gi++) begin : g_col
      // Each column register clears on reset and loads when addressed.
      always_ff @(posedge clk) begin
        if (!reset_i) begin
          mem_q[gi] <= 8'h00;
        end else if (we_i && (waddr_i == COL_W'(gi))) begin
          mem_q[gi] <= wdata_i;
        end
      end
    end
  endgenerate

  // Read is combinational so the scanner sees data in the same cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_loader.sv
// UART frame loader: collects a header + 16 data bytes + XOR checksum into
// the back bank of a double-buffered 16x8 display, and swaps banks at the
// scanner's end-of-scan strobe once a frame has been validated.
module frame_loader
  import frame_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,        // active low, synchronous
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             frame_done,
  input  logic [COL_W-1:0] rd_col,
  output logic [7:0]       rd_data,
  output logic             swap_pending,
  output logic             busy,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             dropped
);

  // Last gap count before a timeout fires: the error pulse then appears
  // exactly TIMEOUT_CYCLES clocks after the last accepted byte.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             bank_sel_q, bank_sel_d;
  logic             swap_pending_q, swap_pending_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic             dropped_q, dropped_d;
  logic             wr_en;
  logic [7:0]       bank_rdata [2];

  // Receive FSM: header detection, data capture, checksum and gap timeout.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    gap_d       = gap_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    dropped_d   = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          if (swap_pending_q) begin
            // Back bank still holds an undisplayed frame; refuse to overwrite.
            dropped_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            idx_d   = '0;
            csum_d  = 8'h00;
          end
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          // Sync-valued bytes are plain data here.
          wr_en  = 1'b1;
          csum_d = csum_q ^ rx_byte;
          idx_d  = idx_q + 1'b1;
          gap_d  = '0;
          if (is_last_col(idx_q)) begin
            state_d = ST_CHECK;
          end
        end else if (gap_q == GAP_LAST) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          gap_d       = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (rx_valid) begin
          gap_d   = '0;
          state_d = ST_IDLE;
          if (rx_byte == csum_q) begin
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (gap_q == GAP_LAST) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          gap_d       = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Bank swap control: a new validated frame takes priority over a swap in
  // the same cycle, which cannot coexist anyway because a frame is only
  // accepted while nothing is pending.
  always_comb begin
    bank_sel_d     = bank_sel_q;
    swap_pending_d = swap_pending_q;
    if (frame_ok_d) begin
      swap_pending_d = 1'b1;
    end else if (frame_done && swap_pending_q) begin
      bank_sel_d     = ~bank_sel_q;
      swap_pending_d = 1'b0;
    end
  end

  // State and status registers; reset abandons any frame silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      csum_q         <= 8'h00;
      gap_q          <= '0;
      bank_sel_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_ok_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      dropped_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      csum_q         <= csum_d;
      gap_q          <= gap_d;
      bank_sel_q     <= bank_sel_d;
      swap_pending_q <= swap_pending_d;
      frame_ok_q     <= frame_ok_d;
      frame_err_q    <= frame_err_d;
      dropped_q      <= dropped_d;
    end
  end

  // Two physical banks; bank_sel picks the front one, writes go to the other.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      frame_bank u_bank (
        .clk     (clk),
        .reset_i (reset),
        .we_i    (wr_en && (bank_sel_q != 1'(gi))),
        .waddr_i (idx_q),
        .wdata_i (rx_byte),
        .raddr_i (rd_col),
        .rdata_o (bank_rdata[gi])
      );
    end
  endgenerate

  assign rd_data      = bank_rdata[bank_sel_q];
  assign swap_pending = swap_pending_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_frame_loader.sv
// Scoreboard bench for frame_loader: stimulus pushes expected pulses, a
// monitor pops and compares; display contents follow a frame-level model.
`timescale 1ns/100ps
module tb_frame_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       frame_done = 1'b0;
  logic [3:0] rd_col = 4'h0;
  logic [7:0] rd_data;
  logic       swap_pending, busy, frame_ok, frame_err, dropped;

  frame_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_done(frame_done), .rd_col(rd_col), .rd_data(rd_data),
    .swap_pending(swap_pending), .busy(busy), .frame_ok(frame_ok),
    .frame_err(frame_err), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_OK = 1, EV_ERR = 2, EV_DROP = 3} ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what the panel shows, the validated image waiting, pending flag.
  logic [7:0] front_m [16];
  logic [7:0] pend_m  [16];
  bit         sp_m;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [7:0] xor16(input logic [7:0] d [16]);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ d[i];
    return x;
  endfunction

  // Monitor: every status pulse must match the oldest expected event.
  initial begin
    ev_t got;
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset && (frame_ok || frame_err || dropped)) begin
        got = frame_ok ? EV_OK : (frame_err ? EV_ERR : EV_DROP);
        check("pulse_exclusive", int'(frame_ok) + int'(frame_err) + int'(dropped), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'(got), 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'(got), int'(e));
        end
      end
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    if (sp_m) begin
      front_m = pend_m;
      sp_m    = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_swap_pending"}, int'(swap_pending), int'(sp_m));
    check({tag, "_busy"}, int'(busy), 0);
    for (int c = 0; c < 16; c++) begin
      rd_col = c[3:0];
      tick();
      check({tag, "_rd_data"}, int'(rd_data), int'(front_m[c]));
    end
  endtask

  // One frame transaction: header, 16 data bytes, then the given checksum.
  task automatic send_frame(input logic [7:0] d [16], input logic [7:0] chk,
                            input bit fd_same);
    bit ok;
    if (sp_m) begin
      exp_q.push_back(EV_DROP);
      send_byte(SYNC, 1);
      return;
    end
    ok = (chk == xor16(d));
    send_byte(SYNC, $urandom_range(0, 2));
    for (int i = 0; i < 16; i++) send_byte(d[i], $urandom_range(0, 2));
    exp_q.push_back(ok ? EV_OK : EV_ERR);
    rx_valid   = 1'b1;
    rx_byte    = chk;
    frame_done = fd_same;
    tick();
    rx_valid   = 1'b0;
    frame_done = 1'b0;
    if (ok) begin
      pend_m = d;
      sp_m   = 1'b1;
    end
    tick();
  endtask

  // Header plus n data bytes, then silence until the timeout fires.
  task automatic do_timeout(input int n);
    int got = -1;
    if (sp_m) pulse_frame_done();
    exp_q.push_back(EV_ERR);
    send_byte(SYNC, 0);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 0);
    for (int k = 1; k <= TMO + 5; k++) begin
      tick();
      if (frame_err && got < 0) got = k;
      if (k == TMO - 1) check("busy_before_timeout", int'(busy), 1);
    end
    check("timeout_latency", got, TMO);
    check("busy_after_timeout", int'(busy), 0);
  endtask

  task automatic rand_frame(output logic [7:0] d [16]);
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic [7:0] d [16];
    logic [7:0] junk;
    int op;

    for (int i = 0; i < 16; i++) begin
      front_m[i] = 8'h00;
      pend_m[i]  = 8'h00;
    end
    sp_m = 1'b0;

    // Reset state.
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_swap_pending", int'(swap_pending), 0);
    check("reset_pulses", int'(frame_ok) + int'(frame_err) + int'(dropped), 0);
    reset = 1'b1;
    tick();
    check_state("after_reset");

    // Known frame 01..10 with correct checksum, then swap.
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    send_frame(d, 8'h10, 1'b0);
    check("known_pending", int'(swap_pending), 1);
    pulse_frame_done();
    check("known_swapped", int'(swap_pending), 0);
    rd_col = 4'd3;
    tick();
    check("known_col3", int'(rd_data), 8'h04);
    check_state("known");

    // Same data, wrong checksum.
    send_frame(d, 8'h00, 1'b0);
    check_state("bad_chk");

    // Valid frame, then header while pending is dropped, then displayed.
    rand_frame(d);
    send_frame(d, xor16(d), 1'b0);
    check_state("pending");
    send_frame(d, 8'h00, 1'b0);
    check_state("dropped");
    pulse_frame_done();
    check_state("after_drop_swap");

    // Timeout after 5 bytes.
    do_timeout(5);
    check_state("timeout5");

    // Checksum byte and frame_done in the same cycle.
    rand_frame(d);
    send_frame(d, xor16(d), 1'b1);
    check_state("fd_same_cycle");
    pulse_frame_done();
    check_state("fd_next_swap");

    // Reset after 8 data bytes.
    send_byte(SYNC, 0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 0);
    reset = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) front_m[i] = 8'h00;
    sp_m = 1'b0;
    check("midreset_busy", int'(busy), 0);
    reset = 1'b1;
    tick();
    check_state("mid_reset");
    rand_frame(d);
    send_frame(d, xor16(d), 1'b0);
    pulse_frame_done();
    check_state("post_reset_frame");

    // Randomized mix of transactions.
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        rand_frame(d);
        if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 15)] = SYNC;
        send_frame(d, xor16(d), 1'b0);
      end else if (op == 3) begin
        rand_frame(d);
        send_frame(d, xor16(d) ^ 8'(1 << $urandom_range(0, 7)), 1'b0);
      end else if (op <= 5) begin
        pulse_frame_done();
      end else if (op == 6) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == SYNC) junk = 8'h5A;
        send_byte(junk, 1);
      end else if (op == 7) begin
        rand_frame(d);
        send_frame(d, xor16(d), 1'b1);
      end else if (op == 8) begin
        if ($urandom_range(0, 2) == 0) do_timeout($urandom_range(0, 16));
      end else begin
        rand_frame(d);
        send_frame(d, xor16(d), 1'b0);
        pulse_frame_done();
      end
      check_state("random");
    end

    repeat (3) tick();
    check("expected_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
